packet_reassembler: RTL
=======================

Name: packet_reassembler

Overview:
Receive-side stage directly downstream of a ring/crossbar node's outbound flit link.
- Collects 64-bit flits (head flit plus body flits) and rebuilds the full 576-bit pkt_t.
- Queues completed packets in a small FIFO and presents them to the core with valid/take handshake.
- Drives the link's free/backpressure signal back to the node.

Parameters:
FLITW, 64, flit width in bits
NFLITS, 9, flits per packet (NFLITS*FLITW = 576 = pkt_t width)
DEPTH, 2, completed-packet queue entries (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_l  input  1  asynchronous active-low reset
flitIn  input  FLITW  flit data from node link
flitValid  input  1  flitIn valid this cycle
headIn  input  1  qualifies flitIn as the packet head flit (with flitValid)
inFree  output  1  to node outboundFree; high = flits will be accepted
pktOut  output  576  head-of-queue packet (pkt_t layout)
pktValid  output  1  queue non-empty, pktOut valid
pktTake  input  1  consumer pops head-of-queue this cycle (ignored if !pktValid)
full  output  1  queue holds DEPTH packets
protoErr  output  1  sticky protocol-error flag, cleared only by reset

Behaviour:
- Reset (async, rst_l=0): state IDLE, flit index 0, queue empty.
- Outputs on reset: inFree=1, pktValid=0, full=0, protoErr=0, pktOut=0.
- Packing is MSB-first:
  - flit 0 = pkt[575:512]: src[63:56], dest[55:48], memoryAddress[47:0].
  - flit k = pkt[575-64k -: 64] for k=1..8 (data, highest word first).
- FSM states: IDLE, COLLECT.
  - IDLE, accepted flit with headIn=1: store as flit 0, idx<=1, go COLLECT.
  - IDLE, accepted flit with headIn=0: discard flit, set protoErr, stay IDLE.
  - COLLECT, accepted flit with headIn=0: store at idx, idx<=idx+1.
  - COLLECT, flit idx==NFLITS-1: store it, push assembled packet into queue on the same edge, idx<=0, go IDLE.
  - COLLECT, accepted flit with headIn=1: abandon the partial packet (never queued), set protoErr, restart with this flit as flit 0, idx<=1.
- A flit is accepted when flitValid && inFree.
- inFree = (queue count < DEPTH) || state==COLLECT.
  - Registered-state function, so it changes the cycle after a push or pop.
  - Pushes occur only at packet completion, so inFree never drops mid-packet.
- flitValid while inFree=0: flit ignored, protoErr set, no state change.
- Latency: last flit accepted at edge N -> pktValid=1 and pktOut valid after edge N; earliest pop at edge N+1.
- Queue:
  - Circular buffer with rd/wr pointers that wrap modulo DEPTH; count 0..DEPTH.
  - pktOut = entry at rd pointer; pktValid = count!=0; full = count==DEPTH.
  - Push and pop in the same cycle: both happen, count unchanged. Allowed when full only if a pop occurs that cycle; when full, inFree=0, so no push normally.
  - pktTake with pktValid=0: no effect.
- Reset mid-packet: partial packet and all queued packets discarded.

Optional Feature:
DEST_CHECK_EN
- Defined:
  - Adds input nodeID [7:0] and output misrouted (1-cycle pulse).
  - On completion, if dest != nodeID, the packet is dropped (not queued) and misrouted pulses for the cycle after the completing edge.
  - protoErr is unaffected by this drop.
- Undefined: no extra ports; every completed packet is queued regardless of dest.

Test Plan:
- Reset, then 9 flits (head = 64'h0003_0000_0000_0101, body words 64'h8888...8 down to 64'h1111...1), pktTake=0 -> pktValid=1 the cycle after flit 8; pktOut[575:512]=64'h0003_0000_0000_0101; pktOut[63:0]=64'h1111_1111_1111_1111.
- Three back-to-back packets with DEPTH=2 and no pops:
  - After packet 2: full=1, inFree=0.
  - Head of packet 3 is ignored and protoErr=1.
  - Pop once -> inFree=1 next cycle.
- Head, 4 body flits, then a new head followed by 8 body flits -> exactly one packet queued (the second), protoErr=1.
- Body flit in IDLE -> discarded, protoErr=1, pktValid stays 0.
- Completion edge coincides with pktTake while count=1 -> count stays 1; pktOut switches to the new packet.
- Assert rst_l=0 asynchronously mid-packet with 1 packet queued -> pktValid=0 and inFree=1 immediately. Then a clean packet completes normally.
- With DEST_CHECK_EN, nodeID=8'h3: a packet with dest=8'h3 is queued; a packet with dest=8'h0 pulses misrouted and pktValid stays 0.

Source files
------------

// File: rtl/packet_reassembler.sv
// -----------------------------------------------------------------------------
// packet_reassembler
//   Receive-side stage behind a ring/crossbar node's outbound flit link.
//   Collects one head flit plus NFLITS-1 body flits, rebuilds the full packet
//   (MSB-first: flit 0 lands in the top FLITW bits), and queues completed
//   packets in a DEPTH-entry circular buffer for the core.
//
// Ports
//   clk        in   clock, rising edge
//   rst_l      in   asynchronous active-low reset
//   flitIn     in   [FLITW-1:0] flit data from the node link
//   flitValid  in   flitIn valid this cycle
//   headIn     in   marks flitIn as a packet head flit
//   inFree     out  high = flits will be accepted (to node outboundFree)
//   pktOut     out  [NFLITS*FLITW-1:0] head-of-queue packet, zero when empty
//   pktValid   out  queue non-empty
//   pktTake    in   pop head-of-queue (ignored when pktValid is low)
//   full       out  queue holds DEPTH packets
//   protoErr   out  sticky protocol-error flag, cleared only by reset
//
// Optional feature (macro DEST_CHECK_EN)
//   Adds nodeID [7:0] input and misrouted output. A completed packet whose
//   dest byte differs from nodeID is dropped and misrouted pulses for one
//   cycle after the completing edge. protoErr is not affected by the drop.
// -----------------------------------------------------------------------------
module packet_reassembler #(
    parameter int FLITW  = 64,
    parameter int NFLITS = 9,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [FLITW-1:0]          flitIn,
    input  logic                      flitValid,
    input  logic                      headIn,
`ifdef DEST_CHECK_EN
    input  logic [7:0]                nodeID,
    output logic                      misrouted,
`endif
    output logic                      inFree,
    output logic [NFLITS*FLITW-1:0]   pktOut,
    output logic                      pktValid,
    input  logic                      pktTake,
    output logic                      full,
    output logic                      protoErr
);
    localparam int PKTW = NFLITS * FLITW;
    localparam int IW   = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            proto_err_q;
    logic            err_set;
    logic            store_en;
    logic [IW-1:0]   store_idx;
    logic            complete;
    logic            push_en;
    logic            do_push, do_pop;
    logic [PKTW-1:0] pkt_asm;

    logic [PKTW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;

    // -------------------------------------------------------------------------
    // Flit storage. The final flit is never stored: it is taken straight from
    // flitIn so the packet can be pushed on the same edge it arrives.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NFLITS; gi++) begin : g_flit
            if (gi < NFLITS - 1) begin : g_store
                logic [FLITW-1:0] flit_q;
                always_ff @(posedge clk) begin
                    if (store_en && store_idx == IW'(gi)) begin
                        flit_q <= flitIn;
                    end
                end
                assign pkt_asm[PKTW-1-gi*FLITW -: FLITW] = flit_q;
            end else begin : g_last
                assign pkt_asm[FLITW-1:0] = flitIn;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Collection FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            proto_err_q <= proto_err_q | err_set;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_set   = 1'b0;
        store_en  = 1'b0;
        store_idx = idx_q;
        complete  = 1'b0;
        if (flitValid && !inFree) begin
            // Sender ignored backpressure: drop the flit, flag it.
            err_set = 1'b1;
        end else if (flitValid) begin
            case (state_q)
                IDLE: begin
                    if (headIn) begin
                        store_en  = 1'b1;
                        store_idx = '0;
                        idx_d     = IW'(1);
                        state_d   = COLLECT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                COLLECT: begin
                    if (headIn) begin
                        // New head mid-packet: abandon partial, restart.
                        err_set   = 1'b1;
                        store_en  = 1'b1;
                        store_idx = '0;
                        idx_d     = IW'(1);
                    end else if (idx_q == IW'(NFLITS - 1)) begin
                        complete = 1'b1;
                        idx_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        store_en = 1'b1;
                        idx_d    = idx_q + IW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

`ifdef DEST_CHECK_EN
    logic misrouted_q;
    logic dest_ok;
    assign dest_ok = (pkt_asm[PKTW-9 -: 8] == nodeID);
    assign push_en = complete && dest_ok;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            misrouted_q <= 1'b0;
        end else begin
            misrouted_q <= complete && !dest_ok;
        end
    end
    assign misrouted = misrouted_q;
`else
    assign push_en = complete;
`endif

    // -------------------------------------------------------------------------
    // Completed-packet queue
    // -------------------------------------------------------------------------
    assign do_pop  = pktTake && (count_q != '0);
    assign do_push = push_en && ((count_q < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= pkt_asm;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Pushes only happen at completion, so inFree cannot fall mid-packet.
    assign inFree   = (count_q < CW'(DEPTH)) || (state_q == COLLECT);
    assign pktValid = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pktOut   = pktValid ? mem_q[rd_ptr_q] : '0;
    assign protoErr = proto_err_q;

endmodule
